// File: rtl/data_mem_unit.sv
// Purpose: byte-addressed little-endian data memory behind the ALU; misaligned accesses split into two word accesses.
// Latency: aligned access responds one cycle after accept, misaligned two cycles after accept.
// Backpressure: req_ready is high only in IDLE; requests offered while busy are ignored and must be held.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset (state, response and rdata only; storage is not cleared)
//   req_valid  request present, req_* held stable until accepted
//   req_ready  unit idle and able to accept (accept = req_valid & req_ready)
//   req_write  1 = store, 0 = load
//   req_addr   byte address; bits above the word index are ignored
//   req_wdata  store bytes, lane k goes to byte addr+k
//   rsp_valid  one-cycle completion pulse
//   rdata      lane k = byte at addr+k of the last load; held between load responses
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPLIT = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  // Rotate a word left by o byte lanes: lane k of the result is lane (k-o) mod 4
  // of w. Lanes o..3 feed the lower word, lanes 0..o-1 the upper word of a split store.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] o);
    logic [63:0] dbl;
    dbl = {w, w};
    return 32'(dbl >> (6'd32 - {1'b0, o, 3'b000}));
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [1:0]       off_q,   off_d;
  logic             write_q, write_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      lo_q,    lo_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_off;
  logic [IDX_W-1:0] hi_idx;
  logic             accept;
  logic [31:0]      rd_acc_word;
  logic [31:0]      rd_hi_word;
  logic [31:0]      st_acc_word;
  logic [3:0]       st_acc_be;
  logic [31:0]      st_hi_word;
  logic [3:0]       st_hi_be;
  logic [31:0]      ld_fmt;
  logic             unused_addr_bits;

  assign acc_idx = req_addr[IDX_W+1:2];
  assign acc_off = req_addr[1:0];
  // Index arithmetic is IDX_W bits wide, so the last word wraps to word 0.
  assign hi_idx  = idx_q + IDX_ONE;

  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rdata     = rdata_q;

  assign accept = req_valid & req_ready;

  assign rd_acc_word = mem[acc_idx];
  assign rd_hi_word  = mem[hi_idx];

  // Lower word takes lanes o..3, upper word lanes 0..o-1 of the same rotation.
  assign st_acc_word = rotl_bytes(req_wdata, acc_off);
  assign st_acc_be   = 4'b1111 << acc_off;
  assign st_hi_word  = rotl_bytes(wdata_q, off_q);
  assign st_hi_be    = ~(4'b1111 << off_q);

  // Load result: 4 bytes starting at lane o of {upper, lower}.
  assign ld_fmt = 32'({rd_hi_word, lo_q} >> {off_q, 3'b000});

  // Storage: not reset. A reset edge suppresses both the accept-edge write and the
  // upper-half write, so a split store interrupted by reset keeps only its lower word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept && req_write) begin
        for (int b = 0; b < 4; b++) begin
          if (st_acc_be[b]) begin
            mem[acc_idx][8*b +: 8] <= st_acc_word[8*b +: 8];
          end
        end
      end
      if ((state_q == ST_SPLIT) && write_q) begin
        for (int b = 0; b < 4; b++) begin
          if (st_hi_be[b]) begin
            mem[hi_idx][8*b +: 8] <= st_hi_word[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    write_d = write_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          idx_d   = acc_idx;
          off_d   = acc_off;
          write_d = req_write;
          wdata_d = req_wdata;
          if (acc_off == 2'd0) begin
            state_d = ST_RESP;
            // Aligned load: the word is the result, visible in the response cycle.
            if (!req_write) begin
              rdata_d = rd_acc_word;
            end
          end else begin
            state_d = ST_SPLIT;
            if (!req_write) begin
              lo_d = rd_acc_word;
            end
          end
        end
      end
      ST_SPLIT: begin
        state_d = ST_RESP;
        if (!write_q) begin
          rdata_d = ld_fmt;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= 2'd0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Purpose: directed self-checking bench for data_mem_unit (table of requests plus corner sequences).
// Latency: checks response one cycle after accept (aligned) or two (misaligned).
// Backpressure: checks req_ready low while busy and that held requests are taken exactly once.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge: inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request from IDLE: accept, optional SPLIT cycle, RESP cycle, back to IDLE.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int lat, input string tag);
    chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
    if (lat == 2) begin
      chk({tag, " rsp_split"}, 32'(rsp_valid), 32'd0);
      tick();
      chk({tag, " ready_busy2"}, 32'(req_ready), 32'd0);
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rdata"}, rdata, exp_rdata);
    tick();
    chk({tag, " rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_cnt;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    // {write, addr, wdata, expected rdata in response cycle, latency}
    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDDCC_BBAA, 32'h0000_0000, 1};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hDDCC_BBAA, 1};
    vecs[2]  = '{1'b1, 32'h0000_0104, 32'h8877_6655, 32'hDDCC_BBAA, 1};
    vecs[3]  = '{1'b1, 32'h0000_0102, 32'h4433_2211, 32'hDDCC_BBAA, 2};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h2211_BBAA, 1};
    vecs[5]  = '{1'b0, 32'h0000_0104, 32'h0,         32'h8877_4433, 1};
    vecs[6]  = '{1'b0, 32'h0000_0103, 32'h0,         32'h7744_3322, 2};
    vecs[7]  = '{1'b0, 32'h0000_0101, 32'h0,         32'h3322_11BB, 2};
    vecs[8]  = '{1'b0, 32'h0000_0102, 32'h0,         32'h4433_2211, 2};
    vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h8765_4321, 32'h4433_2211, 1};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_CAFE, 32'h4433_2211, 1};
    vecs[11] = '{1'b0, 32'h0000_0FFE, 32'h0,         32'hCAFE_8765, 2};
    vecs[12] = '{1'b1, 32'h0000_0FFF, 32'hA1B2_C3D4, 32'hCAFE_8765, 2};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hD465_4321, 1};
    vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         32'h00A1_B2C3, 1};
    vecs[15] = '{1'b0, 32'h0040_1100, 32'h0,         32'h2211_BBAA, 1};

    tick();
    tick();
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // Held request through SPLIT/RESP: second load taken only once back in IDLE.
    rsp_cnt = 0;
    chk("hold ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0103;
    tick();
    req_addr  = 32'h0000_0104;
    chk("hold t1 ready", 32'(req_ready), 32'd0);
    chk("hold t1 rsp", 32'(rsp_valid), 32'd0);
    rsp_cnt += int'(rsp_valid);
    tick();
    chk("hold t2 ready", 32'(req_ready), 32'd0);
    chk("hold t2 rsp", 32'(rsp_valid), 32'd1);
    chk("hold t2 rdata", rdata, 32'h7744_3322);
    rsp_cnt += int'(rsp_valid);
    tick();
    chk("hold t3 ready", 32'(req_ready), 32'd1);
    chk("hold t3 rsp", 32'(rsp_valid), 32'd0);
    rsp_cnt += int'(rsp_valid);
    tick();
    req_valid = 1'b0;
    chk("hold t4 ready", 32'(req_ready), 32'd0);
    chk("hold t4 rsp", 32'(rsp_valid), 32'd1);
    chk("hold t4 rdata", rdata, 32'h8877_4433);
    rsp_cnt += int'(rsp_valid);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold tail%0d ready", c), 32'(req_ready), 32'd1);
      rsp_cnt += int'(rsp_valid);
    end
    chk("hold rsp count", 32'(rsp_cnt), 32'd2);

    // Reset during the SPLIT cycle of a misaligned store.
    do_req(1'b1, 32'h0000_0108, 32'h0BAD_F00D, 32'h8877_4433, 1, "pre108");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0106;
    req_wdata = 32'hEEFF_1122;
    tick();
    req_valid = 1'b0;
    chk("rstsplit split ready", 32'(req_ready), 32'd0);
    chk("rstsplit split rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rstsplit rsp", 32'(rsp_valid), 32'd0);
    chk("rstsplit rdata", rdata, 32'd0);
    chk("rstsplit ready", 32'(req_ready), 32'd1);

    // Reset coincident with a request: the store must not be accepted.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0108;
    req_wdata = 32'hFFFF_FFFF;
    tick();
    req_valid = 1'b0;
    rst_n     = 1'b1;
    chk("rstreq ready", 32'(req_ready), 32'd1);
    chk("rstreq rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("rstreq after ready", 32'(req_ready), 32'd1);
    chk("rstreq after rsp", 32'(rsp_valid), 32'd0);

    do_req(1'b0, 32'h0000_0104, 32'h0, 32'h1122_4433, 1, "post104");
    do_req(1'b0, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 1, "post108");
    do_req(1'b0, 32'h0000_0106, 32'h0, 32'hF00D_1122, 2, "post106");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
